enable_generator_multi: RTL and testbench

Multi-channel, parametrised successor to the single-counter enable generator. It runs one shadow-loaded timebase counter in sawtooth or triangle mode. It emits one registered enable pulse per channel when the counter hits that channel's shadowed threshold, plus a terminal-count pulse. It sits between the register interface (period, thresholds, mode) and the downstream ADC/PWM/DMA trigger consumers that need phase-staggered enables from a single timebase.

---
 rtl/enable_generator_multi.sv | 104 ++++++++++
 tb/tb_enable_generator_multi.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enable_generator_multi.sv
// Shadow-loaded sawtooth/triangle timebase driving N_CHANNELS phase-staggered
// enable pulses and a terminal-count pulse, all registered one clock after the match.
module enable_generator_multi #(
    parameter int COUNTER_WIDTH            = 32,
    parameter int N_CHANNELS               = 4,
    parameter int EXTERNAL_TIMEBASE_ENABLE = 0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 external_timebase,
    input  logic                                 pause,
    input  logic                                 gen_enable_in,
    input  logic                                 count_mode,
    input  logic [COUNTER_WIDTH-1:0]             period,
    input  logic [N_CHANNELS*COUNTER_WIDTH-1:0]  thresholds,
    output logic [COUNTER_WIDTH-1:0]             counter_out,
    output logic                                 direction_out,
    output logic [N_CHANNELS-1:0]                enable_out,
    output logic                                 tc_out
);
    localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

    logic [COUNTER_WIDTH-1:0]            r_counter;
    logic                                r_dir;
    logic [N_CHANNELS-1:0]               r_enable;
    logic                                r_tc;
    logic [COUNTER_WIDTH-1:0]            r_period;
    logic [N_CHANNELS*COUNTER_WIDTH-1:0] r_thresholds;
    logic                                r_mode;

    logic                     w_tick;
    logic                     w_active;
    logic                     w_step;
    logic                     w_load;
    logic                     w_tc;
    logic [COUNTER_WIDTH-1:0] w_pm1;
    logic [N_CHANNELS-1:0]    w_match;

    assign w_tick   = (EXTERNAL_TIMEBASE_ENABLE != 0) ? external_timebase : 1'b1;
    assign w_active = gen_enable_in && (r_period != '0);
    assign w_step   = w_tick && !pause;
    // Shadow reloads only at the period start so a period never mixes old and new values.
    assign w_load   = !gen_enable_in || ((r_counter == '0) && !r_dir);
    assign w_pm1    = r_period - ONE;

    // Last count before returning to 0: P-1 in sawtooth, 1 on the way down in triangle.
    assign w_tc = r_mode ? ((r_counter == ONE) && (r_dir || (r_period == ONE)))
                         : (r_counter == w_pm1);

    for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_match
        assign w_match[gi] = (r_counter == r_thresholds[gi*COUNTER_WIDTH +: COUNTER_WIDTH]);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_counter    <= '0;
            r_dir        <= 1'b0;
            r_enable     <= '0;
            r_tc         <= 1'b0;
            r_period     <= '0;
            r_thresholds <= '0;
            r_mode       <= 1'b0;
        end else begin
            if (w_load) begin
                r_period     <= period;
                r_thresholds <= thresholds;
                r_mode       <= count_mode;
            end
            r_enable <= '0;
            r_tc     <= 1'b0;
            if (!w_active) begin
                if (w_tick) begin
                    r_counter <= '0;
                    r_dir     <= 1'b0;
                end
            end else if (w_step) begin
                r_enable <= r_dir ? '0 : w_match;
                r_tc     <= w_tc;
                if (!r_mode) begin
                    r_dir     <= 1'b0;
                    r_counter <= (r_counter >= w_pm1) ? '0 : r_counter + ONE;
                end else if (!r_dir) begin
                    if (r_counter >= r_period) begin
                        // P=1 turns straight back to 0 and stays counting up.
                        r_counter <= w_pm1;
                        r_dir     <= (w_pm1 != '0);
                    end else begin
                        r_counter <= r_counter + ONE;
                    end
                end else if (r_counter <= ONE) begin
                    r_counter <= '0;
                    r_dir     <= 1'b0;
                end else begin
                    r_counter <= r_counter - ONE;
                end
            end
        end
    end

    assign counter_out   = r_counter;
    assign direction_out = r_dir;
    assign enable_out    = r_enable;
    assign tc_out        = r_tc;
endmodule

// File: tb/tb_enable_generator_multi.sv
// Bench for enable_generator_multi: one internal-timebase and one external-timebase
// instance share stimulus and are checked against a phase-index reference model.
module tb_enable_generator_multi;
    localparam int W = 8;
    localparam int N = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          ext = 1'b1, pause = 1'b0, gen = 1'b0, mode = 1'b0;
    logic [W-1:0]  period = '0;
    logic [N*W-1:0] thr = '0;
    logic [W-1:0]  cnt_o [2];
    logic          dir_o [2];
    logic [N-1:0]  en_o  [2];
    logic          tc_o  [2];

    int tests = 0, fails = 0;

    // Model: phase index k within the period; counter/direction derived from k.
    int unsigned mk [2];
    logic [W-1:0] mP [2];
    logic         mM [2];
    logic [W-1:0] mT [2][N];
    logic [N-1:0] mE [2];
    logic         mTc[2];

    always #5 clock = ~clock;

    enable_generator_multi #(.COUNTER_WIDTH(W), .N_CHANNELS(N), .EXTERNAL_TIMEBASE_ENABLE(0)) u_int (
        .clock(clock), .reset(reset), .external_timebase(ext), .pause(pause),
        .gen_enable_in(gen), .count_mode(mode), .period(period), .thresholds(thr),
        .counter_out(cnt_o[0]), .direction_out(dir_o[0]), .enable_out(en_o[0]), .tc_out(tc_o[0]));

    enable_generator_multi #(.COUNTER_WIDTH(W), .N_CHANNELS(N), .EXTERNAL_TIMEBASE_ENABLE(1)) u_ext (
        .clock(clock), .reset(reset), .external_timebase(ext), .pause(pause),
        .gen_enable_in(gen), .count_mode(mode), .period(period), .thresholds(thr),
        .counter_out(cnt_o[1]), .direction_out(dir_o[1]), .enable_out(en_o[1]), .tc_out(tc_o[1]));

    function automatic logic m_dir(int i);
        return mM[i] && (mP[i] != 0) && (mk[i] > 32'(mP[i]));
    endfunction

    function automatic logic [W-1:0] m_cnt(int i);
        if (m_dir(i)) return W'(2 * 32'(mP[i]) - mk[i]);
        return W'(mk[i]);
    endfunction

    task automatic step_clk();
        @(posedge clock);
        for (int i = 0; i < 2; i++) begin
            logic         tk;
            logic [W-1:0] c;
            logic         d;
            logic         ld;
            int unsigned  len;
            tk  = (i == 0) ? 1'b1 : ext;
            c   = m_cnt(i);
            d   = m_dir(i);
            ld  = !gen || (mk[i] == 0);
            len = mM[i] ? 2 * 32'(mP[i]) : 32'(mP[i]);
            if (!reset) begin
                mk[i] = 0; mP[i] = '0; mM[i] = 1'b0; mE[i] = '0; mTc[i] = 1'b0;
                for (int ch = 0; ch < N; ch++) mT[i][ch] = '0;
            end else begin
                mE[i] = '0; mTc[i] = 1'b0;
                if (!(gen && mP[i] != 0)) begin
                    if (tk) mk[i] = 0;
                end else if (tk && !pause) begin
                    for (int ch = 0; ch < N; ch++)
                        if (!d && c == mT[i][ch]) mE[i][ch] = 1'b1;
                    mTc[i] = (mk[i] == len - 1);
                    mk[i]  = (mk[i] + 1) % len;
                end
                if (ld) begin
                    mP[i] = period; mM[i] = mode;
                    for (int ch = 0; ch < N; ch++) mT[i][ch] = thr[ch*W +: W];
                end
            end
        end
        #1;
    endtask

    task automatic set_cfg(input logic [W-1:0] p, input logic m, input logic [N*W-1:0] t);
        period = p; mode = m; thr = t;
    endtask

    task automatic wait_cnt(input logic [W-1:0] v, input string tag);
        int n = 0;
        while (cnt_o[0] !== v && n < 60) begin step_clk(); n++; end
        tests++;
        if (cnt_o[0] !== v) begin
            fails++;
            $display("FAIL %s wait: counter=%0d required=%0d", tag, cnt_o[0], v);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; gen = 1'b0; pause = 1'b0; ext = 1'b1;
        set_cfg(8'd5, 1'b0, '0);
        step_clk(); step_clk();
        for (int i = 0; i < 2; i++) begin
            tests++;
            if ({cnt_o[i], dir_o[i], en_o[i], tc_o[i]} !== '0) begin
                fails++;
                $display("FAIL reset inst%0d: cnt=%0d dir=%b en=%b tc=%b required all 0",
                         i, cnt_o[i], dir_o[i], en_o[i], tc_o[i]);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_sawtooth();
        int ch3 = 0;
        gen = 1'b0; ext = 1'b1;
        set_cfg(8'd5, 1'b0, {8'd7, 8'd4, 8'd2, 8'd0});
        step_clk();
        gen = 1'b1;
        repeat (16) begin
            step_clk();
            if (en_o[0][3]) ch3++;
            for (int i = 0; i < 2; i++) begin
                tests++;
                if ({cnt_o[i], dir_o[i], en_o[i], tc_o[i]} !== {m_cnt(i), m_dir(i), mE[i], mTc[i]}) begin
                    fails++;
                    $display("FAIL sawtooth inst%0d: cnt=%0d dir=%b en=%b tc=%b required cnt=%0d dir=%b en=%b tc=%b",
                             i, cnt_o[i], dir_o[i], en_o[i], tc_o[i], m_cnt(i), m_dir(i), mE[i], mTc[i]);
                end
            end
        end
        tests++;
        if (ch3 != 0) begin fails++; $display("FAIL sawtooth_ch3: pulses=%0d required=0", ch3); end
    endtask

    task automatic test_triangle();
        gen = 1'b0;
        set_cfg(8'd4, 1'b1, {8'd9, 8'd9, 8'd2, 8'd9});
        step_clk();
        gen = 1'b1;
        repeat (24) begin
            step_clk();
            for (int i = 0; i < 2; i++) begin
                tests++;
                if ({cnt_o[i], dir_o[i], en_o[i], tc_o[i]} !== {m_cnt(i), m_dir(i), mE[i], mTc[i]}) begin
                    fails++;
                    $display("FAIL triangle inst%0d: cnt=%0d dir=%b en=%b tc=%b required cnt=%0d dir=%b en=%b tc=%b",
                             i, cnt_o[i], dir_o[i], en_o[i], tc_o[i], m_cnt(i), m_dir(i), mE[i], mTc[i]);
                end
            end
        end
    endtask

    task automatic test_shadow();
        logic [W-1:0] mx = '0;
        logic         wrapped = 1'b0;
        gen = 1'b0;
        set_cfg(8'd8, 1'b0, {8'd1, 8'd1, 8'd1, 8'd1});
        step_clk();
        gen = 1'b1;
        wait_cnt(8'd5, "shadow");
        set_cfg(8'd3, 1'b0, {8'd6, 8'd6, 8'd2, 8'd6});
        repeat (14) begin
            step_clk();
            if (cnt_o[0] == 0) wrapped = 1'b1;
            if (!wrapped && cnt_o[0] > mx) mx = cnt_o[0];
            for (int i = 0; i < 2; i++) begin
                tests++;
                if ({cnt_o[i], dir_o[i], en_o[i], tc_o[i]} !== {m_cnt(i), m_dir(i), mE[i], mTc[i]}) begin
                    fails++;
                    $display("FAIL shadow inst%0d: cnt=%0d dir=%b en=%b tc=%b required cnt=%0d dir=%b en=%b tc=%b",
                             i, cnt_o[i], dir_o[i], en_o[i], tc_o[i], m_cnt(i), m_dir(i), mE[i], mTc[i]);
                end
            end
        end
        tests++;
        if (mx != 8'd7) begin fails++; $display("FAIL shadow_peak: max=%0d required=7", mx); end
    endtask

    task automatic test_ext_pause();
        gen = 1'b0; ext = 1'b1;
        set_cfg(8'd4, 1'b0, {8'd3, 8'd2, 8'd1, 8'd0});
        step_clk();
        gen = 1'b1;
        for (int c = 0; c < 30; c++) begin
            ext = (c % 3 == 0);
            step_clk();
            for (int i = 0; i < 2; i++) begin
                tests++;
                if ({cnt_o[i], dir_o[i], en_o[i], tc_o[i]} !== {m_cnt(i), m_dir(i), mE[i], mTc[i]}) begin
                    fails++;
                    $display("FAIL ext_tick inst%0d: cnt=%0d dir=%b en=%b tc=%b required cnt=%0d dir=%b en=%b tc=%b",
                             i, cnt_o[i], dir_o[i], en_o[i], tc_o[i], m_cnt(i), m_dir(i), mE[i], mTc[i]);
                end
            end
        end
        ext = 1'b1;
        wait_cnt(8'd3, "pause");
        pause = 1'b1;
        repeat (5) begin
            step_clk();
            tests++;
            if (cnt_o[0] !== 8'd3 || tc_o[0] !== 1'b0 || en_o[0] !== '0) begin
                fails++;
                $display("FAIL pause_hold: cnt=%0d tc=%b en=%b required cnt=3 tc=0 en=0", cnt_o[0], tc_o[0], en_o[0]);
            end
        end
        pause = 1'b0;
        step_clk();
        tests++;
        if (cnt_o[0] !== 8'd0 || tc_o[0] !== 1'b1) begin
            fails++;
            $display("FAIL pause_release: cnt=%0d tc=%b required cnt=0 tc=1", cnt_o[0], tc_o[0]);
        end
    endtask

    task automatic test_disable();
        gen = 1'b0; ext = 1'b1; pause = 1'b0;
        set_cfg(8'd10, 1'b0, {8'd6, 8'd6, 8'd6, 8'd6});
        step_clk();
        gen = 1'b1;
        wait_cnt(8'd6, "disable");
        gen = 1'b0;
        repeat (4) begin
            step_clk();
            for (int i = 0; i < 2; i++) begin
                tests++;
                if ({cnt_o[i], dir_o[i], en_o[i], tc_o[i]} !== '0) begin
                    fails++;
                    $display("FAIL disable inst%0d: cnt=%0d en=%b tc=%b required all 0", i, cnt_o[i], en_o[i], tc_o[i]);
                end
            end
        end
        period = '0;
        step_clk();
        gen = 1'b1;
        repeat (8) begin
            step_clk();
            for (int i = 0; i < 2; i++) begin
                tests++;
                if ({cnt_o[i], dir_o[i], en_o[i], tc_o[i]} !== '0) begin
                    fails++;
                    $display("FAIL zero_period inst%0d: cnt=%0d en=%b tc=%b required all 0", i, cnt_o[i], en_o[i], tc_o[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        gen = 1'b0;
        set_cfg(8'd5, 1'b1, {8'd2, 8'd5, 8'd0, 8'd3});
        step_clk();
        gen = 1'b1;
        wait_cnt(8'd3, "reset_mid");
        reset = 1'b0;
        step_clk();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if ({cnt_o[i], dir_o[i], en_o[i], tc_o[i]} !== '0 || u_int.r_period !== '0) begin
                fails++;
                $display("FAIL reset_mid inst%0d: cnt=%0d dir=%b en=%b tc=%b required all 0", i, cnt_o[i], dir_o[i], en_o[i], tc_o[i]);
            end
        end
        repeat (12) begin
            step_clk();
            for (int i = 0; i < 2; i++) begin
                tests++;
                if ({cnt_o[i], dir_o[i], en_o[i], tc_o[i]} !== {m_cnt(i), m_dir(i), mE[i], mTc[i]}) begin
                    fails++;
                    $display("FAIL after_reset inst%0d: cnt=%0d dir=%b en=%b tc=%b required cnt=%0d dir=%b en=%b tc=%b",
                             i, cnt_o[i], dir_o[i], en_o[i], tc_o[i], m_cnt(i), m_dir(i), mE[i], mTc[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            reset = ($urandom_range(0, 149) != 0);
            gen   = ($urandom_range(0, 29) != 0);
            pause = ($urandom_range(0, 9) == 0);
            ext   = gen ? 1'($urandom_range(0, 1)) : 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                period = ($urandom_range(0, 39) == 0) ? 8'd255 : W'($urandom_range(0, 7));
                mode   = 1'($urandom_range(0, 1));
                for (int ch = 0; ch < N; ch++) thr[ch*W +: W] = W'($urandom_range(0, 9));
            end
            step_clk();
            for (int i = 0; i < 2; i++) begin
                tests++;
                if ({cnt_o[i], dir_o[i], en_o[i], tc_o[i]} !== {m_cnt(i), m_dir(i), mE[i], mTc[i]}) begin
                    fails++;
                    $display("FAIL random inst%0d n=%0d: cnt=%0d dir=%b en=%b tc=%b required cnt=%0d dir=%b en=%b tc=%b",
                             i, n, cnt_o[i], dir_o[i], en_o[i], tc_o[i], m_cnt(i), m_dir(i), mE[i], mTc[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            mk[i] = 0; mP[i] = '0; mM[i] = 1'b0; mE[i] = '0; mTc[i] = 1'b0;
            for (int ch = 0; ch < N; ch++) mT[i][ch] = '0;
        end
        test_reset();
        test_sawtooth();
        test_triangle();
        test_shadow();
        test_ext_pause();
        test_disable();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
